ccu_snoop_arbiter: RTL and testbench

- Shares one snoop port (AC/CR/CD) of the CCU snoop crossbar between NumReq snoop controllers, for example read-snoop and write-snoop FSMs.
- Arbitrates AC requests and records each granted requester in an ordering FIFO.
- Returns each in-order CR response, and any CD data burst that follows it, to the requester that issued the matching AC.
- Sits between the per-channel CCU control FSMs and the snoop crossbar master port.

---
 rtl/ccu_snoop_arbiter.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ccu_snoop_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_snoop_arbiter.sv
// ccu_snoop_arbiter: shares one CCU snoop port (AC/CR/CD) between NumReq snoop controllers.
// AC requests are arbitrated and pass through without a register stage. Every granted
// index is queued in an order FIFO so in-order CR responses return to their issuer. A CR
// carrying DataTransfer (cr_i[0]) queues its owner in a CD FIFO, which steers the
// following CD burst.
// Optional build macro CCU_SNOOP_ARB_FIXED_PRIO_EN: when defined, the lowest index wins
// and the round-robin pointer is removed. The grant lock still applies.
module ccu_snoop_arbiter #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned AcWidth        = 40,
  parameter int unsigned CrWidth        = 5,
  parameter int unsigned CdWidth        = 64,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned IdxWidth       = $clog2(NumReq)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  // Requester side
  input  logic [NumReq-1:0]                 req_ac_valid_i,
  input  logic [NumReq*AcWidth-1:0]         req_ac_i,
  output logic [NumReq-1:0]                 req_ac_ready_o,
  output logic [NumReq-1:0]                 req_cr_valid_o,
  output logic [CrWidth-1:0]                req_cr_o,
  input  logic [NumReq-1:0]                 req_cr_ready_i,
  output logic [NumReq-1:0]                 req_cd_valid_o,
  output logic [CdWidth-1:0]                req_cd_data_o,
  output logic                              req_cd_last_o,
  input  logic [NumReq-1:0]                 req_cd_ready_i,
  // Crossbar side
  output logic                              ac_valid_o,
  output logic [AcWidth-1:0]                ac_o,
  input  logic                              ac_ready_i,
  input  logic                              cr_valid_i,
  input  logic [CrWidth-1:0]                cr_i,
  output logic                              cr_ready_o,
  input  logic                              cd_valid_i,
  input  logic [CdWidth-1:0]                cd_data_i,
  input  logic                              cd_last_i,
  output logic                              cd_ready_o,
  output logic [$clog2(MaxOutstanding):0]   outstanding_o
);

  localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
  localparam int unsigned CntWidth = PtrWidth + 1;
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(MaxOutstanding);

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [IdxWidth-1:0] arb_grant, grant;
  logic                arb_found;
  logic                lock_q, lock_d;
  logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
  logic                ac_hs;

`ifndef CCU_SNOOP_ARB_FIXED_PRIO_EN
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  int unsigned         rr_cand;
`endif

  // Order FIFO: one entry per AC issued whose CR has not completed
  logic [IdxWidth-1:0] ord_mem_q [MaxOutstanding];
  logic [IdxWidth-1:0] ord_mem_d [MaxOutstanding];
  logic [PtrWidth-1:0] ord_wptr_q, ord_wptr_d, ord_rptr_q, ord_rptr_d;
  logic [CntWidth-1:0] ord_cnt_q, ord_cnt_d;
  logic                ord_full, ord_empty;
  logic [IdxWidth-1:0] ord_head;

  // CD FIFO: owners of DataTransfer CRs whose data burst has not completed
  logic [IdxWidth-1:0] cd_mem_q [MaxOutstanding];
  logic [IdxWidth-1:0] cd_mem_d [MaxOutstanding];
  logic [PtrWidth-1:0] cd_wptr_q, cd_wptr_d, cd_rptr_q, cd_rptr_d;
  logic [CntWidth-1:0] cd_cnt_q, cd_cnt_d;
  logic                cd_full, cd_empty;
  logic [IdxWidth-1:0] cd_head;

  logic                cr_block;
  logic                cr_hs, cd_push, cd_hs, cd_pop;

  assign ord_full  = (ord_cnt_q == FullCnt);
  assign ord_empty = (ord_cnt_q == '0);
  assign ord_head  = ord_mem_q[ord_rptr_q];
  assign cd_full   = (cd_cnt_q == FullCnt);
  assign cd_empty  = (cd_cnt_q == '0);
  assign cd_head   = cd_mem_q[cd_rptr_q];

  // ---------------------------------------------------------------------------
  // AC arbitration
  // ---------------------------------------------------------------------------
  // Pick a requester for a fresh (unlocked) AC
  always_comb begin : p_arb
    arb_found = 1'b0;
`ifdef CCU_SNOOP_ARB_FIXED_PRIO_EN
    arb_grant = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!arb_found && req_ac_valid_i[IdxWidth'(i)]) begin
        arb_grant = IdxWidth'(i);
        arb_found = 1'b1;
      end
    end
`else
    arb_grant = rr_ptr_q;
    rr_cand   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      rr_cand = 32'(rr_ptr_q) + i;
      if (rr_cand >= NumReq) rr_cand = rr_cand - NumReq;
      if (!arb_found && req_ac_valid_i[IdxWidth'(rr_cand)]) begin
        arb_grant = IdxWidth'(rr_cand);
        arb_found = 1'b1;
      end
    end
`endif
  end

  // Drive the crossbar AC channel. A pending AC keeps its grant until it handshakes.
  always_comb begin : p_ac_out
    grant          = lock_q ? lock_idx_q : arb_grant;
    ac_valid_o     = (lock_q ? req_ac_valid_i[lock_idx_q] : |req_ac_valid_i) && !ord_full;
    ac_o           = '0;
    req_ac_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (grant == IdxWidth'(i)) begin
        ac_o = req_ac_i[i*AcWidth +: AcWidth];
      end
    end
    req_ac_ready_o[grant] = ac_ready_i && !ord_full;
    ac_hs                 = ac_valid_o && ac_ready_i;
  end

  // Lock is set for every cycle the AC is offered but not accepted
  always_comb begin : p_lock_next
    lock_d     = ac_valid_o && !ac_ready_i;
    lock_idx_d = grant;
  end

`ifndef CCU_SNOOP_ARB_FIXED_PRIO_EN
  // Advance the round-robin pointer past the requester just served
  always_comb begin : p_rr_next
    rr_ptr_d = rr_ptr_q;
    if (ac_hs) begin
      rr_ptr_d = (32'(grant) + 1 >= NumReq) ? '0 : grant + IdxWidth'(1);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_rr_q
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // CR / CD routing
  // ---------------------------------------------------------------------------
  // Steer CR to the oldest outstanding AC's owner. A DataTransfer CR waits for CD FIFO space.
  always_comb begin : p_cr_route
    cr_block       = cr_i[0] && cd_full;
    req_cr_valid_o = '0;
    cr_ready_o     = 1'b0;
    req_cr_o       = cr_i;
    if (!ord_empty) begin
      // Gate the requester-side valid as well so both sides see the same handshake
      req_cr_valid_o[ord_head] = cr_valid_i && !cr_block;
      cr_ready_o               = req_cr_ready_i[ord_head] && !cr_block;
    end
    cr_hs   = cr_valid_i && cr_ready_o;
    cd_push = cr_hs && cr_i[0];
  end

  // Steer CD beats to the owner of the oldest DataTransfer CR
  always_comb begin : p_cd_route
    req_cd_valid_o = '0;
    cd_ready_o     = 1'b0;
    req_cd_data_o  = cd_data_i;
    req_cd_last_o  = cd_last_i;
    if (!cd_empty) begin
      req_cd_valid_o[cd_head] = cd_valid_i;
      cd_ready_o              = req_cd_ready_i[cd_head];
    end
    cd_hs  = cd_valid_i && cd_ready_o;
    cd_pop = cd_hs && cd_last_i;
  end

  // ---------------------------------------------------------------------------
  // FIFO next state
  // ---------------------------------------------------------------------------
  // Order FIFO: push on AC handshake, pop on CR handshake
  always_comb begin : p_ord_next
    ord_mem_d  = ord_mem_q;
    ord_wptr_d = ord_wptr_q;
    ord_rptr_d = ord_rptr_q;
    ord_cnt_d  = ord_cnt_q;
    if (ac_hs) begin
      ord_mem_d[ord_wptr_q] = grant;
      ord_wptr_d            = ord_wptr_q + PtrWidth'(1);
    end
    if (cr_hs) begin
      ord_rptr_d = ord_rptr_q + PtrWidth'(1);
    end
    unique case ({ac_hs, cr_hs})
      2'b10:   ord_cnt_d = ord_cnt_q + CntWidth'(1);
      2'b01:   ord_cnt_d = ord_cnt_q - CntWidth'(1);
      default: ord_cnt_d = ord_cnt_q;
    endcase
  end

  // CD FIFO: push on DataTransfer CR handshake, pop on the last CD beat
  always_comb begin : p_cd_next
    cd_mem_d  = cd_mem_q;
    cd_wptr_d = cd_wptr_q;
    cd_rptr_d = cd_rptr_q;
    cd_cnt_d  = cd_cnt_q;
    if (cd_push) begin
      cd_mem_d[cd_wptr_q] = ord_head;
      cd_wptr_d           = cd_wptr_q + PtrWidth'(1);
    end
    if (cd_pop) begin
      cd_rptr_d = cd_rptr_q + PtrWidth'(1);
    end
    unique case ({cd_push, cd_pop})
      2'b10:   cd_cnt_d = cd_cnt_q + CntWidth'(1);
      2'b01:   cd_cnt_d = cd_cnt_q - CntWidth'(1);
      default: cd_cnt_d = cd_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // Grant lock and both FIFOs
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_state_q
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      ord_wptr_q <= '0;
      ord_rptr_q <= '0;
      ord_cnt_q  <= '0;
      cd_wptr_q  <= '0;
      cd_rptr_q  <= '0;
      cd_cnt_q   <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        ord_mem_q[i] <= '0;
        cd_mem_q[i]  <= '0;
      end
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      ord_wptr_q <= ord_wptr_d;
      ord_rptr_q <= ord_rptr_d;
      ord_cnt_q  <= ord_cnt_d;
      cd_wptr_q  <= cd_wptr_d;
      cd_rptr_q  <= cd_rptr_d;
      cd_cnt_q   <= cd_cnt_d;
      ord_mem_q  <= ord_mem_d;
      cd_mem_q   <= cd_mem_d;
    end
  end

  assign outstanding_o = ord_cnt_q;

endmodule

// File: tb/tb_ccu_snoop_arbiter.sv
// Scoreboard bench for ccu_snoop_arbiter: directed stimulus pushes expected AC/CR/CD
// transfers into queues; a negedge monitor pops and compares on every handshake.
module tb_ccu_snoop_arbiter;
  localparam int unsigned NumReq  = 2;
  localparam int unsigned AcWidth = 40;
  localparam int unsigned CrWidth = 5;
  localparam int unsigned CdWidth = 64;
  localparam int unsigned MaxOut  = 4;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [NumReq-1:0]           req_ac_valid = '0;
  logic [NumReq*AcWidth-1:0]   req_ac = '0;
  logic [NumReq-1:0]           req_ac_ready;
  logic [NumReq-1:0]           req_cr_valid;
  logic [CrWidth-1:0]          req_cr;
  logic [NumReq-1:0]           req_cr_ready = '0;
  logic [NumReq-1:0]           req_cd_valid;
  logic [CdWidth-1:0]          req_cd_data;
  logic                        req_cd_last;
  logic [NumReq-1:0]           req_cd_ready = '0;
  logic                        ac_valid;
  logic [AcWidth-1:0]          ac;
  logic                        ac_ready = 1'b0;
  logic                        cr_valid = 1'b0;
  logic [CrWidth-1:0]          cr = '0;
  logic                        cr_ready;
  logic                        cd_valid = 1'b0;
  logic [CdWidth-1:0]          cd_data = '0;
  logic                        cd_last = 1'b0;
  logic                        cd_ready;
  logic [$clog2(MaxOut):0]     outstanding;

  ccu_snoop_arbiter #(
    .NumReq         (NumReq),
    .AcWidth        (AcWidth),
    .CrWidth        (CrWidth),
    .CdWidth        (CdWidth),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_ac_valid_i (req_ac_valid),
    .req_ac_i       (req_ac),
    .req_ac_ready_o (req_ac_ready),
    .req_cr_valid_o (req_cr_valid),
    .req_cr_o       (req_cr),
    .req_cr_ready_i (req_cr_ready),
    .req_cd_valid_o (req_cd_valid),
    .req_cd_data_o  (req_cd_data),
    .req_cd_last_o  (req_cd_last),
    .req_cd_ready_i (req_cd_ready),
    .ac_valid_o     (ac_valid),
    .ac_o           (ac),
    .ac_ready_i     (ac_ready),
    .cr_valid_i     (cr_valid),
    .cr_i           (cr),
    .cr_ready_o     (cr_ready),
    .cd_valid_i     (cd_valid),
    .cd_data_i      (cd_data),
    .cd_last_i      (cd_last),
    .cd_ready_o     (cd_ready),
    .outstanding_o  (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [AcWidth-1:0] pl; }                 ac_exp_t;
  typedef struct { int idx; logic [CrWidth-1:0] pl; }                 cr_exp_t;
  typedef struct { int idx; logic [CdWidth-1:0] data; logic last; }   cd_exp_t;

  ac_exp_t exp_ac[$];
  cr_exp_t exp_cr[$];
  cd_exp_t exp_cd[$];
  ac_exp_t mon_ac;
  cr_exp_t mon_cr;
  cd_exp_t mon_cd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ac(input int idx, input logic [AcWidth-1:0] pl);
    ac_exp_t e;
    e.idx = idx;
    e.pl  = pl;
    exp_ac.push_back(e);
  endtask

  task automatic push_cr(input int idx, input logic [CrWidth-1:0] pl);
    cr_exp_t e;
    e.idx = idx;
    e.pl  = pl;
    exp_cr.push_back(e);
  endtask

  task automatic push_cd(input int idx, input logic [CdWidth-1:0] d, input logic last);
    cd_exp_t e;
    e.idx  = idx;
    e.data = d;
    e.last = last;
    exp_cd.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ac_valid"},     64'(ac_valid),     64'd0);
    check({tag, "_req_ac_ready"}, 64'(req_ac_ready), 64'd0);
    check({tag, "_req_cr_valid"}, 64'(req_cr_valid), 64'd0);
    check({tag, "_cr_ready"},     64'(cr_ready),     64'd0);
    check({tag, "_req_cd_valid"}, 64'(req_cd_valid), 64'd0);
    check({tag, "_cd_ready"},     64'(cd_ready),     64'd0);
    check({tag, "_outstanding"},  64'(outstanding),  64'd0);
  endtask

  // Monitor: every handshake seen on the crossbar side must match the next expected item
  always @(negedge clk) begin
    if (rst_n) begin
      if (ac_valid && ac_ready) begin
        check("ac_expected", 64'(exp_ac.size() != 0), 64'd1);
        if (exp_ac.size() != 0) begin
          mon_ac = exp_ac.pop_front();
          check("ac_grant",   64'(req_ac_ready), 64'(1) << mon_ac.idx);
          check("ac_payload", 64'(ac),           64'(mon_ac.pl));
        end
      end
      if (cr_valid && cr_ready) begin
        check("cr_expected", 64'(exp_cr.size() != 0), 64'd1);
        if (exp_cr.size() != 0) begin
          mon_cr = exp_cr.pop_front();
          check("cr_owner",   64'(req_cr_valid), 64'(1) << mon_cr.idx);
          check("cr_payload", 64'(req_cr),       64'(mon_cr.pl));
        end
      end
      if (cd_valid && cd_ready) begin
        check("cd_expected", 64'(exp_cd.size() != 0), 64'd1);
        if (exp_cd.size() != 0) begin
          mon_cd = exp_cd.pop_front();
          check("cd_owner", 64'(req_cd_valid), 64'(1) << mon_cd.idx);
          check("cd_data",  64'(req_cd_data),  mon_cd.data);
          check("cd_last",  64'(req_cd_last),  64'(mon_cd.last));
        end
      end
    end
  end

  localparam logic [AcWidth-1:0] A0 = 40'hA0_0000_0000, A1 = 40'hA1_1111_1111;
  localparam logic [AcWidth-1:0] B0 = 40'hB0_0000_00B0, B1 = 40'hB1_0000_00B1;
  localparam logic [AcWidth-1:0] C0 = 40'hC0_0000_00C0, C1 = 40'hC1_0000_00C1;
  localparam logic [AcWidth-1:0] D0 = 40'hD0_0000_00D0, D1 = 40'hD1_0000_00D1;
  localparam logic [AcWidth-1:0] E0 = 40'hE0_0000_00E0, E1 = 40'hE1_0000_00E1;

  initial begin
    logic [CrWidth-1:0] drain_cr [4];
    int                 drain_own [4];
    drain_cr  = '{5'h02, 5'h04, 5'h06, 5'h08};
    drain_own = '{1, 0, 1, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    tick();

    // Round-robin alternation and order-FIFO full
    req_ac = {A1, A0};
    push_ac(0, A0); push_ac(1, A1); push_ac(0, A0); push_ac(1, A1);
    req_ac_valid = 2'b11;
    ac_ready     = 1'b1;
    repeat (4) tick();
    check("full_outstanding", 64'(outstanding),  64'd4);
    check("full_ac_valid",    64'(ac_valid),     64'd0);
    check("full_ac_ready",    64'(req_ac_ready), 64'd0);
    ac_ready     = 1'b0;
    req_cr_ready = 2'b11;
    cr           = 5'h00;
    cr_valid     = 1'b1;
    push_cr(0, 5'h00);
    tick();
    cr_valid = 1'b0;
    check("after_pop_outstanding", 64'(outstanding), 64'd3);
    check("after_pop_ac_valid",    64'(ac_valid),    64'd1);
    push_ac(0, A0);
    ac_ready = 1'b1;
    tick();
    ac_ready     = 1'b0;
    req_ac_valid = '0;
    check("refill_outstanding", 64'(outstanding), 64'd4);
    // Only the wrong requester ready: CR must stall
    req_cr_ready = 2'b01;
    cr           = drain_cr[0];
    cr_valid     = 1'b1;
    #1;
    check("cr_wrong_ready_stall", 64'(cr_ready), 64'd0);
    tick();
    req_cr_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      push_cr(drain_own[i], drain_cr[i]);
      cr = drain_cr[i];
      tick();
    end
    cr_valid = 1'b0;
    check("drain_outstanding", 64'(outstanding), 64'd0);

    // Grant lock: pointer now favours requester 1, but requester 0 holds the AC
    req_ac       = {B1, B0};
    req_ac_valid = 2'b01;
    repeat (3) tick();
    check("lock_valid",   64'(ac_valid), 64'd1);
    check("lock_pre",     64'(ac),       64'(B0));
    req_ac_valid = 2'b11;
    #2;
    check("lock_raise",   64'(ac),       64'(B0));
    tick();
    check("lock_hold",    64'(ac),       64'(B0));
    push_ac(0, B0); push_ac(1, B1);
    ac_ready = 1'b1;
    tick();
    req_ac_valid = 2'b10;
    tick();
    req_ac_valid = '0;
    ac_ready     = 1'b0;
    check("lock_outstanding", 64'(outstanding), 64'd2);
    cr_valid = 1'b1;
    push_cr(0, 5'h10); cr = 5'h10; tick();
    push_cr(1, 5'h12); cr = 5'h12; tick();
    cr_valid = 1'b0;

    // CD routing: AC order 1,0; DataTransfer CR to 1, plain CR to 0, burst to 1
    req_ac   = {C1, C0};
    ac_ready = 1'b1;
    req_ac_valid = 2'b10; push_ac(1, C1); tick();
    req_ac_valid = 2'b01; push_ac(0, C0); tick();
    req_ac_valid = '0;
    ac_ready     = 1'b0;
    cr_valid = 1'b1;
    push_cr(1, 5'h01); cr = 5'h01; tick();
    push_cr(0, 5'h00); cr = 5'h00; tick();
    cr_valid     = 1'b0;
    req_cd_ready = 2'b11;
    cd_valid     = 1'b1;
    for (int b = 0; b < 4; b++) begin
      cd_data = 64'hCD00_0000_0000_0000 + 64'(b);
      cd_last = (b == 3);
      if (b == 2) begin
        req_cd_ready = 2'b01;
        #1;
        check("cd_wrong_ready_stall", 64'(cd_ready), 64'd0);
        tick();
        req_cd_ready = 2'b11;
      end
      push_cd(1, cd_data, cd_last);
      tick();
    end
    cd_last = 1'b0;
    check("cd_empty_ready", 64'(cd_ready),     64'd0);
    check("cd_empty_valid", 64'(req_cd_valid), 64'd0);
    cd_valid = 1'b0;

    // CR with nothing outstanding
    cr       = 5'h01;
    cr_valid = 1'b1;
    #1;
    check("cr_no_ac_ready", 64'(cr_ready),     64'd0);
    check("cr_no_ac_valid", 64'(req_cr_valid), 64'd0);
    tick();
    cr_valid = 1'b0;

    // Reset mid-operation: 2 outstanding plus a CD burst in flight
    req_ac   = {D1, D0};
    ac_ready = 1'b1;
    req_ac_valid = 2'b01; push_ac(0, D0); tick();
    req_ac_valid = 2'b10; push_ac(1, D1); tick();
    req_ac_valid = 2'b01; push_ac(0, D0); tick();
    req_ac_valid = '0;
    ac_ready     = 1'b0;
    check("mid_outstanding3", 64'(outstanding), 64'd3);
    cr_valid = 1'b1; cr = 5'h01; push_cr(0, 5'h01); tick();
    cr_valid = 1'b0;
    check("mid_outstanding2", 64'(outstanding), 64'd2);
    cd_valid = 1'b1; cd_last = 1'b0; cd_data = 64'h0123_4567_89AB_CDEF;
    push_cd(0, cd_data, 1'b0);
    tick();
    rst_n    = 1'b0;
    cr_valid = 1'b1;
    cr       = 5'h01;
    #1;
    check_idle("midreset");
    tick();
    cr_valid = 1'b0;
    cd_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    req_ac       = {E1, E0};
    req_ac_valid = 2'b11;
    ac_ready     = 1'b1;
    push_ac(0, E0);
    tick();
    req_ac_valid = '0;
    ac_ready     = 1'b0;
    check("post_reset_outstanding", 64'(outstanding), 64'd1);

    repeat (2) tick();
    check("ac_queue_drained", 64'(exp_ac.size()), 64'd0);
    check("cr_queue_drained", 64'(exp_cr.size()), 64'd0);
    check("cd_queue_drained", 64'(exp_cd.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
